// File: rtl/cond_pkg.sv
// Shared definitions for the condition evaluation path: condition-code
// encodings and the bit positions of the {N,Z,C,V} flags word.
package cond_pkg;

  // Condition codes. The carry flag follows the borrow convention, so
  // LO/HS test C directly rather than its complement.
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_LO = 4'd2;
  localparam logic [3:0] COND_HS = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Bit positions inside the 4-bit flags word {N,Z,C,V}.
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage : cond_pkg

// File: rtl/cond_eval_unit_if.sv
// Request/response handshake bundle between issue/decode (master) and the
// condition evaluation unit (slave). The master presents condition requests
// and consumes responses; the slave accepts requests and produces responses.
interface cond_eval_unit_if #(
  parameter int TAG_W = 5
) ();

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_taken;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid,
    output req_cond,
    output req_tag,
    input  req_ready,
    input  rsp_valid,
    input  rsp_taken,
    input  rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_cond,
    input  req_tag,
    output req_ready,
    output rsp_valid,
    output rsp_taken,
    output rsp_tag,
    input  rsp_ready
  );

endinterface : cond_eval_unit_if

// File: rtl/cond_decode.sv
// Pure combinational condition-code evaluator: (cond, {N,Z,C,V}) -> taken.
// Kept standalone so predicated-execution logic can reuse it directly.
module cond_decode
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLG_N];
  assign w_z = i_flags[FLG_Z];
  assign w_c = i_flags[FLG_C];
  assign w_v = i_flags[FLG_V];

  // Map each condition code onto its flag expression; NV is reserved and
  // never taken.
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_LO: o_taken = w_c;
      COND_HS: o_taken = !w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = !w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = !w_v;
      COND_HI: o_taken = !w_c && !w_z;
      COND_LS: o_taken = w_c || w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = !w_z && (w_n == w_v);
      COND_LE: o_taken = w_z || (w_n != w_v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
    endcase
  end

endmodule : cond_decode

// File: rtl/cond_eval_unit.sv
// Condition evaluation unit: owns the architectural {N,Z,C,V} flags, counts
// flag writes that are issued but not yet written back, and answers
// condition requests only once the flags they depend on are current.
//
// Build option COND_FWD_EN: when defined, a flag writeback is forwarded into
// the evaluation in the same cycle, so a request waiting on the last
// outstanding write is accepted in the writeback cycle. When undefined, the
// unit waits for the flags register to settle, which costs one bubble cycle
// after every writeback.
module cond_eval_unit
  import cond_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  cond_eval_unit_if.slave   bus,
  input  logic              flg_issue,
  input  logic              flg_we,
  input  logic [3:0]        flg_in,
  output logic [3:0]        flags_q,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              err
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
`ifdef COND_FWD_EN
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
`endif

  logic [3:0]        r_flags;
  logic [PEND_W-1:0] r_pendCnt;
  logic              r_err;
  logic              r_rspValid;
  logic              r_rspTaken;
  logic [TAG_W-1:0]  r_rspTag;

  logic              w_pendZero;
  logic              w_pendSat;
  logic              w_slotFree;
  logic              w_flagsOk;
  logic [3:0]        w_evalFlags;
  logic              w_reqReady;
  logic              w_accept;
  logic              w_taken;
  logic              w_errEvent;

  assign w_pendZero = (r_pendCnt == '0);
  assign w_pendSat  = (r_pendCnt == PEND_MAX);

  // The single output register can take a new response when it is empty or
  // its current content is being consumed this cycle.
  assign w_slotFree = !r_rspValid || bus.rsp_ready;

`ifdef COND_FWD_EN
  // Flags are usable if nothing is outstanding, or the only outstanding
  // write lands this cycle (and no new one is issued alongside it); in that
  // case the incoming value is evaluated directly.
  assign w_flagsOk   = w_pendZero ||
                       ((r_pendCnt == PEND_ONE) && flg_we && !flg_issue);
  assign w_evalFlags = flg_we ? flg_in : r_flags;
`else
  // Without forwarding, any writeback in flight makes the register stale
  // until the following cycle.
  assign w_flagsOk   = w_pendZero && !flg_we;
  assign w_evalFlags = r_flags;
`endif

  // Ready never looks at req_valid; holding it low during reset keeps a
  // request presented in the reset cycle from appearing accepted.
  assign w_reqReady = w_slotFree && w_flagsOk && !rst;
  assign w_accept   = bus.req_valid && w_reqReady;

  cond_decode u_decode (
    .i_cond  (bus.req_cond),
    .i_flags (w_evalFlags),
    .o_taken (w_taken)
  );

  // A retirement with nothing pending, or an issue with the counter already
  // full, means the producer and this unit disagree about outstanding writes.
  assign w_errEvent = (flg_we && !flg_issue && w_pendZero) ||
                      (flg_issue && !flg_we && w_pendSat);

  // Architectural flags register: every writeback lands, even unexpected ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (flg_we) begin
      r_flags <= flg_in;
    end
  end

  // Outstanding flag-write counter: issue and retire in the same cycle
  // cancel; it neither wraps above the maximum nor goes below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendCnt <= '0;
    end else begin
      case ({flg_issue, flg_we})
        2'b10: begin
          if (!w_pendSat) begin
            r_pendCnt <= r_pendCnt + 1'b1;
          end
        end
        2'b01: begin
          if (!w_pendZero) begin
            r_pendCnt <= r_pendCnt - 1'b1;
          end
        end
        default: begin
          r_pendCnt <= r_pendCnt;
        end
      endcase
    end
  end

  // Protocol error flag stays set until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_errEvent) begin
      r_err <= 1'b1;
    end
  end

  // Response slot: load on accept, empty when consumed with no replacement,
  // and otherwise hold its payload stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspTaken <= 1'b0;
      r_rspTag   <= '0;
    end else if (w_accept) begin
      r_rspValid <= 1'b1;
      r_rspTaken <= w_taken;
      r_rspTag   <= bus.req_tag;
    end else if (bus.rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_taken = r_rspTaken;
  assign bus.rsp_tag   = r_rspTag;

  assign flags_q  = r_flags;
  assign pend_cnt = r_pendCnt;
  assign err      = r_err;

endmodule : cond_eval_unit

// File: tb/tb_cond_eval_unit.sv
// Directed self-checking bench for cond_eval_unit: a table of hand-computed
// condition vectors, a full code x flags sweep against a truth-table model,
// and hand-written sequences for stalls, back-pressure, counter limits and
// reset. Expectations follow COND_FWD_EN the same way the design does.
module tb_cond_eval_unit;

  localparam int TAG_W  = 5;
  localparam int PEND_W = 3;
  localparam int NUM_VEC = 19;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       expTaken;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              flg_issue;
  logic              flg_we;
  logic [3:0]        flg_in;
  logic [3:0]        flags_q;
  logic [PEND_W-1:0] pend_cnt;
  logic              err;

  int checks;
  int failures;

  vec_t vecs [NUM_VEC];

  cond_eval_unit_if #(.TAG_W(TAG_W)) bus ();

  cond_eval_unit #(
    .TAG_W  (TAG_W),
    .PEND_W (PEND_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flg_issue (flg_issue),
    .flg_we    (flg_we),
    .flg_in    (flg_in),
    .flags_q   (flags_q),
    .pend_cnt  (pend_cnt),
    .err       (err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Independent truth-table model of the condition codes (C = borrow).
  function automatic logic modelTaken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return ~(cy | z);
      4'd9:  return cy | z;
      4'd10: return ~(n ^ v);
      4'd11: return n ^ v;
      4'd12: return ~z & ~(n ^ v);
      4'd13: return z | (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Load a flags value, then issue one request and sample its response.
  task automatic applyStimulus(input vec_t v, input int idx);
    flg_we = 1'b1;
    flg_in = v.flags;
    step();
    flg_we        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cond  = v.cond;
    bus.req_tag   = 5'(idx);
    step();
    bus.req_valid = 1'b0;
    checkOutput($sformatf("vec%0d_valid", idx), int'(bus.rsp_valid), 1);
    checkOutput($sformatf("vec%0d_taken", idx), int'(bus.rsp_taken), int'(v.expTaken));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Hand-computed vectors: {cond, flags {N,Z,C,V}, expected taken}.
    vecs[0]  = '{4'd0,  4'b0100, 1'b1};
    vecs[1]  = '{4'd1,  4'b0100, 1'b0};
    vecs[2]  = '{4'd2,  4'b0010, 1'b1};
    vecs[3]  = '{4'd3,  4'b0010, 1'b0};
    vecs[4]  = '{4'd4,  4'b1000, 1'b1};
    vecs[5]  = '{4'd5,  4'b1000, 1'b0};
    vecs[6]  = '{4'd6,  4'b0001, 1'b1};
    vecs[7]  = '{4'd7,  4'b0001, 1'b0};
    vecs[8]  = '{4'd8,  4'b0000, 1'b1};
    vecs[9]  = '{4'd8,  4'b0100, 1'b0};
    vecs[10] = '{4'd9,  4'b0010, 1'b1};
    vecs[11] = '{4'd10, 4'b1001, 1'b1};
    vecs[12] = '{4'd11, 4'b1000, 1'b1};
    vecs[13] = '{4'd12, 4'b0000, 1'b1};
    vecs[14] = '{4'd12, 4'b0100, 1'b0};
    vecs[15] = '{4'd13, 4'b1000, 1'b1};
    vecs[16] = '{4'd13, 4'b0000, 1'b0};
    vecs[17] = '{4'd14, 4'b0000, 1'b1};
    vecs[18] = '{4'd15, 4'b1111, 1'b0};

    rst           = 1'b1;
    flg_issue     = 1'b0;
    flg_we        = 1'b0;
    flg_in        = 4'b0000;
    bus.req_valid = 1'b0;
    bus.req_cond  = 4'd0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state.
    checkOutput("rst_flags", int'(flags_q), 0);
    checkOutput("rst_pend", int'(pend_cnt), 0);
    checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("rst_rsp_taken", int'(bus.rsp_taken), 0);
    checkOutput("rst_rsp_tag", int'(bus.rsp_tag), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_req_ready", int'(bus.req_ready), 1);

    // Unexpected writeback with nothing pending, then EQ request.
    flg_we = 1'b1;
    flg_in = 4'b0100;
    step();
    flg_we = 1'b0;
    checkOutput("wb0_flags", int'(flags_q), 4);
    checkOutput("wb0_err", int'(err), 1);
    checkOutput("wb0_pend", int'(pend_cnt), 0);
    bus.req_valid = 1'b1;
    bus.req_cond  = 4'd0;
    bus.req_tag   = 5'd3;
    #1;
    checkOutput("eq_req_ready", int'(bus.req_ready), 1);
    step();
    bus.req_valid = 1'b0;
    checkOutput("eq_rsp_valid", int'(bus.rsp_valid), 1);
    checkOutput("eq_rsp_taken", int'(bus.rsp_taken), 1);
    checkOutput("eq_rsp_tag", int'(bus.rsp_tag), 3);
    step();
    checkOutput("eq_drain", int'(bus.rsp_valid), 0);

    // Table-driven vectors.
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i], i);
    end
    step();

    // Full sweep of codes x flags, back-to-back requests.
    for (int f = 0; f < 16; f++) begin
      flg_we = 1'b1;
      flg_in = 4'(f);
      step();
      flg_we = 1'b0;
      checkOutput($sformatf("sweep_flags_f%0d", f), int'(flags_q), f);
      for (int c = 0; c < 16; c++) begin
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'(c);
        bus.req_tag   = 5'(c);
        step();
        checkOutput($sformatf("sweep_c%0d_f%0d", c, f),
                    int'({bus.rsp_valid, bus.rsp_taken, bus.rsp_tag}),
                    int'({1'b1, modelTaken(4'(c), 4'(f)), 5'(c)}));
      end
      bus.req_valid = 1'b0;
      step();
    end

    // Stall on a pending flag write, released by its writeback.
    doReset();
    flg_issue = 1'b1;
    step();
    flg_issue = 1'b0;
    checkOutput("stall_pend1", int'(pend_cnt), 1);
    bus.req_valid = 1'b1;
    bus.req_cond  = 4'd12;
    bus.req_tag   = 5'd5;
    #1;
    checkOutput("stall_ready_a", int'(bus.req_ready), 0);
    step();
    checkOutput("stall_ready_b", int'(bus.req_ready), 0);
    checkOutput("stall_no_rsp", int'(bus.rsp_valid), 0);
    step();
    flg_we = 1'b1;
    flg_in = 4'b0000;
    #1;
`ifdef COND_FWD_EN
    checkOutput("wb_cycle_ready", int'(bus.req_ready), 1);
    step();
    flg_we        = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("fwd_rsp_valid", int'(bus.rsp_valid), 1);
    checkOutput("fwd_rsp_taken", int'(bus.rsp_taken), 1);
    checkOutput("fwd_rsp_tag", int'(bus.rsp_tag), 5);
    checkOutput("fwd_pend0", int'(pend_cnt), 0);
`else
    checkOutput("wb_cycle_ready", int'(bus.req_ready), 0);
    step();
    flg_we = 1'b0;
    checkOutput("bubble_no_rsp", int'(bus.rsp_valid), 0);
    checkOutput("bubble_pend0", int'(pend_cnt), 0);
    #1;
    checkOutput("bubble_ready", int'(bus.req_ready), 1);
    step();
    bus.req_valid = 1'b0;
    checkOutput("bubble_rsp_valid", int'(bus.rsp_valid), 1);
    checkOutput("bubble_rsp_taken", int'(bus.rsp_taken), 1);
    checkOutput("bubble_rsp_tag", int'(bus.rsp_tag), 5);
`endif
    step();

    // Back-pressure: full slot holds and blocks, then drains in order.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cond  = 4'd14;
    bus.req_tag   = 5'd10;
    step();
    checkOutput("bp_first_valid", int'(bus.rsp_valid), 1);
    checkOutput("bp_first_tag", int'(bus.rsp_tag), 10);
    bus.req_cond = 4'd15;
    bus.req_tag  = 5'd11;
    #1;
    checkOutput("bp_ready_full", int'(bus.req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("bp_hold%0d_valid", k), int'(bus.rsp_valid), 1);
      checkOutput($sformatf("bp_hold%0d_tag", k), int'(bus.rsp_tag), 10);
      checkOutput($sformatf("bp_hold%0d_taken", k), int'(bus.rsp_taken), 1);
      checkOutput($sformatf("bp_hold%0d_ready", k), int'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp_ready_release", int'(bus.req_ready), 1);
    step();
    checkOutput("bp_second_tag", int'(bus.rsp_tag), 11);
    checkOutput("bp_second_taken", int'(bus.rsp_taken), 0);
    bus.req_cond = 4'd14;
    bus.req_tag  = 5'd12;
    step();
    bus.req_valid = 1'b0;
    checkOutput("bp_third_tag", int'(bus.rsp_tag), 12);
    checkOutput("bp_third_taken", int'(bus.rsp_taken), 1);
    step();
    checkOutput("bp_drain", int'(bus.rsp_valid), 0);

    // Simultaneous issue and writeback leave the count unchanged.
    doReset();
    flg_issue = 1'b1;
    step();
    step();
    checkOutput("sim_pend2", int'(pend_cnt), 2);
    flg_we = 1'b1;
    flg_in = 4'b1000;
    step();
    flg_issue = 1'b0;
    flg_we    = 1'b0;
    checkOutput("sim_pend_hold", int'(pend_cnt), 2);
    checkOutput("sim_err", int'(err), 0);
    checkOutput("sim_flags", int'(flags_q), 8);

    // Saturation: eight issues without writeback.
    doReset();
    flg_issue = 1'b1;
    for (int k = 0; k < 7; k++) step();
    flg_issue = 1'b0;
    checkOutput("sat_pend7_noerr", int'(err), 0);
    flg_issue = 1'b1;
    step();
    flg_issue = 1'b0;
    checkOutput("sat_pend", int'(pend_cnt), 7);
    checkOutput("sat_err", int'(err), 1);

    // Reset with a held response and pending writes.
    doReset();
    flg_we = 1'b1;
    flg_in = 4'b1111;
    step();
    flg_we        = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cond  = 4'd14;
    bus.req_tag   = 5'd7;
    step();
    bus.req_valid = 1'b0;
    checkOutput("pre_rst_valid", int'(bus.rsp_valid), 1);
    flg_issue = 1'b1;
    for (int k = 0; k < 3; k++) step();
    flg_issue = 1'b0;
    checkOutput("pre_rst_pend", int'(pend_cnt), 3);
    checkOutput("pre_rst_err", int'(err), 1);
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_tag   = 5'd9;
    step();
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("mid_rst_flags", int'(flags_q), 0);
    checkOutput("mid_rst_pend", int'(pend_cnt), 0);
    checkOutput("mid_rst_valid", int'(bus.rsp_valid), 0);
    checkOutput("mid_rst_taken", int'(bus.rsp_taken), 0);
    checkOutput("mid_rst_tag", int'(bus.rsp_tag), 0);
    checkOutput("mid_rst_err", int'(err), 0);
    step();
    checkOutput("post_rst_no_accept", int'(bus.rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cond_eval_unit
